ts_scan_ctrl: RTL and testbench
===============================

// Module: ts_scan_ctrl
// PURPOSE
//   Polls N_CH temperature sensors in turn through one shared read port (req/ack).
//   Keeps a per-channel over-temperature alarm with +/-TH hysteresis around the threshold thr.
//   Reports the hottest channel of each completed scan.
//   Sits between the sensor read mux and the thermal management logic; one instance per die.
// PARAMETERS
//   N_CH        4     number of sensor channels (2..16)
//   CH_W        2     width of channel index, = clog2(N_CH)
//   SCAN_PERIOD 1000  clk cycles between scan start ticks (>= N_CH*(TIMEOUT+3))
//   TIMEOUT     15    max cycles to wait for rd_ack before abandoning a channel
// PORTS
//   clk        in   1       system clock, all logic on posedge
//   rst        in   1       asynchronous, active-low reset
//   en         in   1       scan enable, sampled only in IDLE at a period tick
//   thr        in   8       signed alarm threshold (deg C), sampled at UPDATE
//   rd_req     out  1       read request to shared sensor port
//   rd_ch      out  CH_W    channel being read, stable while rd_req=1
//   rd_ack     in   1       read complete; rd_data valid this cycle
//   rd_data    in   8       signed sensor sample
//   alarm      out  N_CH    per-channel hysteretic over-temperature flag
//   err        out  N_CH    per-channel flag, 1 = last read of this channel timed out
//   any_alarm  out  1       OR of alarm
//   max_temp   out  8       signed hottest sample of last completed scan
//   max_ch     out  CH_W    channel of max_temp
//   max_valid  out  1       1 = at least one channel responded in last completed scan
//   busy       out  1       1 = FSM not in IDLE
//   scan_done  out  1       one-cycle pulse after last channel of a scan updates
//   overrun    out  1       sticky: period tick while busy; cleared by reset only
// BEHAVIOUR
//   Reset values:
//     - all outputs 0, except max_temp = 8'sh80 (-128).
//     - FSM = IDLE, period counter = 0.
//   Period counter:
//     - free-running 0..SCAN_PERIOD-1; tick when count = SCAN_PERIOD-1.
//     - tick in IDLE with en=1 -> REQ with ch=0; tick in IDLE with en=0 -> ignored.
//     - tick while busy -> overrun<=1, tick dropped.
//   FSM IDLE -> REQ -> WAIT -> UPD -> (REQ for ch+1 | DONE) -> IDLE.
//     - REQ: rd_req=1 and rd_ch=ch from this cycle on.
//     - WAIT: hold rd_req=1 and rd_ch; on rd_ack, capture rd_data and go to UPD.
//     - rd_req is 0 in the cycle after ack.
//     - WAIT, timeout: wait counter hits TIMEOUT with no ack -> err[ch]<=1, alarm[ch] unchanged,
//       channel excluded from max, go to UPD (no flag update). A late ack arriving after the
//       timeout is ignored.
//     - UPD, with sample: err[ch]<=0; hysteresis as below; running max updates if
//       sample > run_max (strict, so lower index wins ties).
//     - UPD, after timeout: no flag update.
//     - UPD, next step: ch = N_CH-1 -> DONE, else ch+1 -> REQ.
//     - DONE: scan_done=1 for one cycle; latch run_max, run_ch and run_valid into
//       max_temp, max_ch and max_valid; reset run_max to -128; go to IDLE.
//   Hysteresis, computed in 10-bit signed (no wrap):
//     - alarm=0 and sample > thr+TH -> alarm set.
//     - alarm=1 and sample < thr-TH -> alarm cleared.
//     - otherwise hold.
//   Other rules:
//     - en falling mid-scan: current scan completes normally; no new scan starts.
//     - rst asserted mid-transaction: rd_req drops immediately (async); all state returns to
//       reset values.
//     - thr changes mid-scan: each channel uses thr as sampled in its own UPD cycle.
//     - rd_ack while rd_req=0: ignored.
// STRUCTURE
//   - ts_pkg holds: state enum (IDLE, REQ, WAIT, UPD, DONE), TH = 8'sd5, DATA_W = 8,
//     TEMP_MIN = 8'sh80.
//   - Sub-module ts_hyst_update: combinational next-alarm from (alarm, sample, thr).
//     Instantiated once and shared across channels through the FSM's UPD step.
// TESTING
//   1. Reset, en=1, thr=50, ch0..3 ack after 2 cycles with 40/60/52/60.
//      -> alarm=4'b1010, max_temp=60, max_ch=1, max_valid=1; scan_done pulses once;
//         rd_req low between channels.
//   2. Hysteresis on ch0, thr=50, successive scans 56,50,46,44.
//      -> alarm[0] sequence 1,1,1,0; 55 alone never sets alarm.
//   3. ch2 never acks. -> after TIMEOUT cycles err[2]=1, alarm[2] held, ch3 still read.
//      Next scan ch2 acks -> err[2]=0.
//   4. All channels time out. -> max_valid=0, max_temp=-128; scan_done still pulses.
//   5. Acks delayed so a scan exceeds SCAN_PERIOD. -> overrun=1 sticky, next scan starts only
//      at first tick seen in IDLE. en=0 at ch1 -> scan finishes, no further rd_req.
//   6. Assert rst during WAIT. -> rd_req=0 the same cycle, outputs at reset values; scanning
//      resumes at ch0 on first tick after release.

Source files
------------

// File: rtl/ts_pkg.sv
// Shared definitions for the temperature scan controller slice.
//   DATA_W   : sensor sample / threshold width (signed degrees C)
//   TH       : alarm hysteresis half-width around the threshold
//   TEMP_MIN : most negative sample, used as the running-max seed
//   state_t  : scan FSM states
package ts_pkg;

   localparam int DATA_W = 8;

   localparam logic signed [DATA_W-1:0] TH       = 8'sd5;
   localparam logic signed [DATA_W-1:0] TEMP_MIN = 8'sh80;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      UPD  = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/ts_scan_ctrl_if.sv
// Shared sensor read port.
//   rd_req  : read request, driven by the scan controller
//   rd_ch   : channel being read, stable while rd_req=1
//   rd_ack  : read complete, rd_data valid in the same cycle
//   rd_data : signed sensor sample
// master = scan controller side, slave = sensor mux side.
interface ts_scan_ctrl_if #(
   parameter int CH_W = 2
) ();

   logic                             rd_req;
   logic [CH_W-1:0]                  rd_ch;
   logic                             rd_ack;
   logic signed [ts_pkg::DATA_W-1:0] rd_data;

   modport master (
      output rd_req,
      output rd_ch,
      input  rd_ack,
      input  rd_data
   );

   modport slave (
      input  rd_req,
      input  rd_ch,
      output rd_ack,
      output rd_data
   );

endinterface

// File: rtl/ts_hyst_update.sv
// Combinational next-state of one channel's over-temperature alarm.
//   alarm     : current alarm flag of the channel
//   sample    : signed sensor sample
//   thr       : signed threshold
//   alarm_nxt : alarm after applying +/-TH hysteresis
// Arithmetic is widened to 10 bits so thr+/-TH cannot wrap at the
// ends of the 8-bit range.
module ts_hyst_update
   import ts_pkg::*;
(
   input  logic                     alarm,
   input  logic signed [DATA_W-1:0] sample,
   input  logic signed [DATA_W-1:0] thr,
   output logic                     alarm_nxt
);

   localparam int EW = DATA_W + 2;

   logic signed [EW-1:0] s_w;
   logic signed [EW-1:0] t_w;
   logic signed [EW-1:0] th_w;
   logic signed [EW-1:0] hi;
   logic signed [EW-1:0] lo;

   always_comb begin
      s_w  = {{(EW-DATA_W){sample[DATA_W-1]}}, sample};
      t_w  = {{(EW-DATA_W){thr[DATA_W-1]}}, thr};
      th_w = {{(EW-DATA_W){TH[DATA_W-1]}}, TH};
      hi   = t_w + th_w;
      lo   = t_w - th_w;
      alarm_nxt = alarm;
      if (!alarm && (s_w > hi)) begin
         alarm_nxt = 1'b1;
      end else if (alarm && (s_w < lo)) begin
         alarm_nxt = 1'b0;
      end
   end

endmodule

// File: rtl/ts_scan_ctrl.sv
// Round-robin temperature sensor scanner.
// Every SCAN_PERIOD cycles (when enabled and idle) reads channels 0..N_CH-1
// through the shared read port, updates per-channel hysteretic alarms and
// timeout flags, and publishes the hottest responding channel of the scan.
//   clk, rst   : clock, asynchronous active-low reset
//   en         : scan enable, looked at only on a period tick in IDLE
//   thr        : signed alarm threshold, used in each channel's UPD cycle
//   rd         : shared sensor read port (master side)
//   alarm/err  : per-channel over-temperature / last-read-timed-out flags
//   any_alarm  : OR of alarm
//   max_temp, max_ch, max_valid : result of the last completed scan
//   busy       : FSM not in IDLE
//   scan_done  : one-cycle pulse at the end of a scan
//   overrun    : sticky, a period tick arrived while busy
module ts_scan_ctrl
   import ts_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int CH_W        = 2,
   parameter int SCAN_PERIOD = 1000,
   parameter int TIMEOUT     = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] thr,
   ts_scan_ctrl_if.master           rd,
   output logic [N_CH-1:0]          alarm,
   output logic [N_CH-1:0]          err,
   output logic                     any_alarm,
   output logic signed [DATA_W-1:0] max_temp,
   output logic [CH_W-1:0]          max_ch,
   output logic                     max_valid,
   output logic                     busy,
   output logic                     scan_done,
   output logic                     overrun
);

   localparam int PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   state_t                     state;
   logic [PW-1:0]              pcnt;
   logic [WW-1:0]              wcnt;
   logic [CH_W-1:0]            ch;
   logic signed [DATA_W-1:0]   smp;
   logic                       got;
   logic signed [DATA_W-1:0]   run_max;
   logic [CH_W-1:0]            run_ch;
   logic                       run_valid;
   logic                       tick;
   logic                       alarm_nxt;

   ts_hyst_update u_hyst (
      .alarm     (alarm[ch]),
      .sample    (smp),
      .thr       (thr),
      .alarm_nxt (alarm_nxt)
   );

   always_comb begin
      tick      = (pcnt == PW'(SCAN_PERIOD - 1));
      rd.rd_req = (state == REQ) || (state == WAIT);
      rd.rd_ch  = ch;
      busy      = (state != IDLE);
      scan_done = (state == DONE);
      any_alarm = |alarm;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         pcnt      <= '0;
         wcnt      <= '0;
         ch        <= '0;
         smp       <= '0;
         got       <= 1'b0;
         run_max   <= TEMP_MIN;
         run_ch    <= '0;
         run_valid <= 1'b0;
         alarm     <= '0;
         err       <= '0;
         max_temp  <= TEMP_MIN;
         max_ch    <= '0;
         max_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         pcnt <= tick ? '0 : pcnt + 1'b1;

         // A tick that finds the FSM busy is dropped, only recorded.
         if (tick && (state != IDLE)) begin
            overrun <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (tick && en) begin
                  ch    <= '0;
                  state <= REQ;
               end
            end
            REQ: begin
               wcnt  <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (rd.rd_ack) begin
                  smp   <= rd.rd_data;
                  got   <= 1'b1;
                  state <= UPD;
               end else if (wcnt == WW'(TIMEOUT - 1)) begin
                  got     <= 1'b0;
                  err[ch] <= 1'b1;
                  state   <= UPD;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            UPD: begin
               if (got) begin
                  err[ch]   <= 1'b0;
                  alarm[ch] <= alarm_nxt;
                  run_valid <= 1'b1;
                  // First responder always seeds the max, so a -128 sample
                  // still names its own channel; afterwards strict > keeps
                  // the lower index on ties.
                  if (!run_valid || (smp > run_max)) begin
                     run_max <= smp;
                     run_ch  <= ch;
                  end
               end
               if (ch == CH_W'(N_CH - 1)) begin
                  state <= DONE;
               end else begin
                  ch    <= ch + 1'b1;
                  state <= REQ;
               end
            end
            DONE: begin
               max_temp  <= run_max;
               max_ch    <= run_ch;
               max_valid <= run_valid;
               run_max   <= TEMP_MIN;
               run_ch    <= '0;
               run_valid <= 1'b0;
               ch        <= '0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ts_scan_ctrl.sv
module tb_ts_scan_ctrl;

   localparam int N_CH = 4;
   localparam int CH_W = 2;
   // Short period with a long timeout so a slow scan can overlap a tick.
   localparam int SP   = 40;
   localparam int TOUT = 10;

   logic                clk;
   logic                rst;
   logic                en;
   logic signed [7:0]   thr;
   logic [N_CH-1:0]     alarm;
   logic [N_CH-1:0]     err;
   logic                any_alarm;
   logic signed [7:0]   max_temp;
   logic [CH_W-1:0]     max_ch;
   logic                max_valid;
   logic                busy;
   logic                scan_done;
   logic                overrun;

   ts_scan_ctrl_if #(.CH_W(CH_W)) bus ();

   ts_scan_ctrl #(
      .N_CH        (N_CH),
      .CH_W        (CH_W),
      .SCAN_PERIOD (SP),
      .TIMEOUT     (TOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .thr       (thr),
      .rd        (bus),
      .alarm     (alarm),
      .err       (err),
      .any_alarm (any_alarm),
      .max_temp  (max_temp),
      .max_ch    (max_ch),
      .max_valid (max_valid),
      .busy      (busy),
      .scan_done (scan_done),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   // sensor model configuration
   logic signed [7:0] cfg_smp [N_CH];
   int                cfg_dly [N_CH];
   logic [N_CH-1:0]   cfg_resp;
   bit                cfg_spur;

   typedef struct {
      logic signed [7:0]       thr;
      logic [N_CH-1:0][7:0]    smp;
      logic [N_CH-1:0]         resp;
      bit                      spur;
      logic [N_CH-1:0]         e_alarm;
      logic [N_CH-1:0]         e_err;
      logic signed [7:0]       e_max;
      logic [CH_W-1:0]         e_ch;
      logic                    e_valid;
   } vec_t;

   typedef struct {
      logic [N_CH-1:0]   alarm;
      logic [N_CH-1:0]   err;
      logic signed [7:0] max;
      logic [CH_W-1:0]   ch;
      logic              valid;
   } exp_t;

   vec_t tbl [13];
   exp_t sb [$];

   // Sensor side: acks cfg_dly cycles after rd_req rises for a channel;
   // with cfg_spur it also pulses ack (data 127) whenever rd_req is low.
   initial begin : sensor
      bit              act;
      int              age;
      logic [CH_W-1:0] cur;
      act = 1'b0;
      age = 0;
      cur = '0;
      bus.rd_ack  = 1'b0;
      bus.rd_data = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.rd_req) begin
            if (!act || (bus.rd_ch != cur)) begin
               act = 1'b1;
               cur = bus.rd_ch;
               age = 0;
            end else begin
               age++;
            end
            if (cfg_resp[cur] && (age == cfg_dly[cur])) begin
               bus.rd_ack  = 1'b1;
               bus.rd_data = cfg_smp[cur];
            end else begin
               bus.rd_ack  = 1'b0;
               bus.rd_data = '0;
            end
         end else begin
            act = 1'b0;
            bus.rd_ack  = cfg_spur;
            bus.rd_data = cfg_spur ? 8'sd127 : 8'sd0;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic signed [7:0] t,
      input logic signed [7:0] s0, input logic signed [7:0] s1,
      input logic signed [7:0] s2, input logic signed [7:0] s3,
      input logic [3:0] r, input bit sp,
      input logic [3:0] ea, input logic [3:0] ee,
      input logic signed [7:0] em, input logic [1:0] ec, input logic ev);
      vec_t v;
      v.thr     = t;
      v.smp     = {s3, s2, s1, s0};
      v.resp    = r;
      v.spur    = sp;
      v.e_alarm = ea;
      v.e_err   = ee;
      v.e_max   = em;
      v.e_ch    = ec;
      v.e_valid = ev;
      return v;
   endfunction

   task automatic wait_busy(input logic lvl, input int budget, input string nm);
      int n;
      n = 0;
      while ((busy !== lvl) && (n < budget)) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy !== lvl) begin
         checks++;
         errors++;
         $display("FAIL %s: busy=%b after %0d cycles, expected %b", nm, busy, n, lvl);
      end
   endtask

   task automatic load_vec(input int i);
      exp_t e;
      thr = tbl[i].thr;
      for (int c = 0; c < N_CH; c++) begin
         cfg_smp[c] = tbl[i].smp[c];
         cfg_dly[c] = 1 + ((i + c) % 4);
      end
      cfg_resp = tbl[i].resp;
      cfg_spur = tbl[i].spur;
      e.alarm = tbl[i].e_alarm;
      e.err   = tbl[i].e_err;
      e.max   = tbl[i].e_max;
      e.ch    = tbl[i].e_ch;
      e.valid = tbl[i].e_valid;
      sb.push_back(e);
   endtask

   task automatic finish_scan(input int i);
      int   n;
      int   sd;
      int   low;
      exp_t e;
      wait_busy(1'b1, 2 * SP + 4, $sformatf("v%0d start", i));
      sd = 0;
      low = 0;
      n = 0;
      while (busy && (n < 400)) begin
         if (scan_done) sd++;
         if (!bus.rd_req) low++;
         @(posedge clk);
         #1;
         n++;
      end
      chk($sformatf("v%0d scan end", i), 32'(busy), 32'd0);
      if (sb.size() == 0) begin
         chk($sformatf("v%0d scoreboard", i), 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk($sformatf("v%0d alarm", i),     32'(alarm),     32'(e.alarm));
         chk($sformatf("v%0d err", i),       32'(err),       32'(e.err));
         chk($sformatf("v%0d max_temp", i),  32'(max_temp),  32'(e.max));
         chk($sformatf("v%0d max_ch", i),    32'(max_ch),    32'(e.ch));
         chk($sformatf("v%0d max_valid", i), 32'(max_valid), 32'(e.valid));
         chk($sformatf("v%0d any_alarm", i), 32'(any_alarm), 32'(|e.alarm));
      end
      chk($sformatf("v%0d scan_done pulses", i), 32'(sd), 32'd1);
      chk($sformatf("v%0d rd_req low cycles", i), 32'(low), 32'(N_CH + 1));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " rd_req"},    32'(bus.rd_req), 32'd0);
      chk({tag, " rd_ch"},     32'(bus.rd_ch),  32'd0);
      chk({tag, " alarm"},     32'(alarm),      32'd0);
      chk({tag, " err"},       32'(err),        32'd0);
      chk({tag, " any_alarm"}, 32'(any_alarm),  32'd0);
      chk({tag, " max_temp"},  32'(max_temp),   32'hFFFF_FF80);
      chk({tag, " max_ch"},    32'(max_ch),     32'd0);
      chk({tag, " max_valid"}, 32'(max_valid),  32'd0);
      chk({tag, " busy"},      32'(busy),       32'd0);
      chk({tag, " scan_done"}, 32'(scan_done),  32'd0);
      chk({tag, " overrun"},   32'(overrun),    32'd0);
   endtask

   initial begin : main
      int t0;
      int t1;
      int n;
      int rises;
      logic prev;

      //           thr    ch0      ch1      ch2      ch3      resp     spur  alarm    err      max      ch     valid
      tbl[0]  = mk(8'sd50,   8'sd40,  8'sd60,  8'sd52,  8'sd60,  4'b1111, 1'b0, 4'b1010, 4'b0000, 8'sd60,  2'd1, 1'b1);
      tbl[1]  = mk(8'sd50,   8'sd56,  8'sd50,  8'sd50,  8'sd50,  4'b1111, 1'b0, 4'b1011, 4'b0000, 8'sd56,  2'd0, 1'b1);
      tbl[2]  = mk(8'sd50,   8'sd50,  8'sd50,  8'sd50,  8'sd50,  4'b1111, 1'b1, 4'b1011, 4'b0000, 8'sd50,  2'd0, 1'b1);
      tbl[3]  = mk(8'sd50,   8'sd46,  8'sd50,  8'sd50,  8'sd50,  4'b1111, 1'b0, 4'b1011, 4'b0000, 8'sd50,  2'd1, 1'b1);
      tbl[4]  = mk(8'sd50,   8'sd44,  8'sd50,  8'sd50,  8'sd50,  4'b1111, 1'b0, 4'b1010, 4'b0000, 8'sd50,  2'd1, 1'b1);
      tbl[5]  = mk(8'sd50,   8'sd55,  8'sd50,  8'sd60,  8'sd50,  4'b1111, 1'b0, 4'b1110, 4'b0000, 8'sd60,  2'd2, 1'b1);
      tbl[6]  = mk(8'sd50,   8'sd30,  8'sd30,  8'sd0,   8'sd70,  4'b1011, 1'b1, 4'b1100, 4'b0100, 8'sd70,  2'd3, 1'b1);
      tbl[7]  = mk(8'sd50,   8'sd50,  8'sd50,  8'sd50,  8'sd50,  4'b1111, 1'b0, 4'b1100, 4'b0000, 8'sd50,  2'd0, 1'b1);
      tbl[8]  = mk(8'sd125,  8'sd127, 8'sd127, 8'sd127, 8'sd127, 4'b1111, 1'b0, 4'b1100, 4'b0000, 8'sd127, 2'd0, 1'b1);
      tbl[9]  = mk(-8'sd125, 8'sh80,  8'sh80,  8'sh80,  8'sh80,  4'b1111, 1'b0, 4'b1100, 4'b0000, 8'sh80,  2'd0, 1'b1);
      tbl[10] = mk(-8'sd125, 8'sd0,   8'sh80,  8'sh80,  8'sh80,  4'b1110, 1'b0, 4'b1100, 4'b0001, 8'sh80,  2'd1, 1'b1);
      tbl[11] = mk(-8'sd125, -8'sd119, 8'sh80, 8'sh80,  8'sh80,  4'b1111, 1'b0, 4'b1101, 4'b0000, -8'sd119, 2'd0, 1'b1);
      tbl[12] = mk(8'sd50,   8'sd0,   8'sd0,   8'sd0,   8'sd0,   4'b0000, 1'b0, 4'b0000, 4'b1111, 8'sh80,  2'd0, 1'b0);

      rst = 1'b0;
      en  = 1'b0;
      thr = 8'sd0;
      cfg_resp = '0;
      cfg_spur = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
         cfg_smp[c] = '0;
         cfg_dly[c] = 1;
      end

      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");

      @(negedge clk);
      rst = 1'b1;
      en  = 1'b1;

      for (int i = 0; i < 12; i++) begin
         load_vec(i);
         finish_scan(i);
      end
      chk("no overrun on short scans", 32'(overrun), 32'd0);

      // slow scan overlapping a tick, then en dropped mid-scan
      thr = 8'sd50;
      cfg_resp = 4'b1111;
      cfg_spur = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
         cfg_smp[c] = 8'sd20;
         cfg_dly[c] = TOUT - 1;
      end
      wait_busy(1'b1, 2 * SP + 4, "slow start");
      t0 = cyc;
      wait_busy(1'b0, 200, "slow end");
      chk("overrun set", 32'(overrun), 32'd1);
      wait_busy(1'b1, 2 * SP + 4, "restart");
      t1 = cyc;
      chk("restart interval", 32'(t1 - t0), 32'(2 * SP));
      n = 0;
      while (!(bus.rd_req && (bus.rd_ch == 2'd1)) && (n < 100)) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("reached ch1", 32'(bus.rd_ch), 32'd1);
      en = 1'b0;
      n = 0;
      rises = 0;
      while (busy && (n < 200)) begin
         if (scan_done) rises++;
         @(posedge clk);
         #1;
         n++;
      end
      chk("en drop scan completes", 32'(rises), 32'd1);
      rises = 0;
      prev = bus.rd_req;
      for (int k = 0; k < 3 * SP; k++) begin
         @(posedge clk);
         #1;
         if (bus.rd_req && !prev) rises++;
         prev = bus.rd_req;
      end
      chk("no rd_req with en=0", 32'(rises), 32'd0);
      chk("overrun sticky", 32'(overrun), 32'd1);

      // reset in WAIT
      en = 1'b1;
      wait_busy(1'b1, 2 * SP + 4, "pre-reset start");
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("in WAIT before reset", 32'(bus.rd_req), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_reset_vals("async reset");
      load_vec(12);
      @(negedge clk);
      rst = 1'b1;
      n = 0;
      while (!busy && (n < 2 * SP)) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("first tick after release", 32'(n), 32'(SP));
      chk("resume at ch0", 32'(bus.rd_ch), 32'd0);
      finish_scan(12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
